router_3to1_arbiter: RTL and testbench

Merging counterpart of the 1x3 router: collects 8-bit beats from three independent input ports and forwards them, one per cycle, onto a single registered output port with valid/ready flow control. Fair round-robin arbitration selects among requesting ports. Each output beat is tagged with its source port using the same 2-bit port encoding the 1x3 router uses as its control select. The block sits upstream of a shared consumer, typically a 1x3 router or a common sink.

---
 rtl/router_pkg.sv | 37 +++
 rtl/rr_arbiter3.sv | 46 ++++
 rtl/router_3to1_arbiter.sv | 121 ++++++++++++
 tb/tb_router_3to1_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: port encoding, lock-FSM state type and one-hot helpers shared
// by the router family (1x3 router, 3-to-1 arbiter, rr_arbiter3).
package router_pkg;

    localparam int NUM_PORTS = 3;

    typedef logic [1:0] port_id_t;

    localparam port_id_t PORT0      = 2'b00;
    localparam port_id_t PORT1      = 2'b01;
    localparam port_id_t PORT2      = 2'b10;
    localparam port_id_t PORT_BCAST = 2'b11;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_t;

    function automatic logic [NUM_PORTS-1:0] port_to_onehot(input port_id_t p);
        case (p)
            PORT0:   return 3'b001;
            PORT1:   return 3'b010;
            PORT2:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // An all-zero vector maps to PORT0; callers qualify it with a valid.
    function automatic port_id_t onehot_to_port(input logic [NUM_PORTS-1:0] oh);
        case (oh)
            3'b010:  return PORT1;
            3'b100:  return PORT2;
            default: return PORT0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: combinational one-hot round-robin grant over three requesters;
// the search starts one past the registered last-grant pointer.
module rr_arbiter3
    import router_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_upd,
    input  port_id_t             i_upd_port,
    output logic [NUM_PORTS-1:0] o_grant
);

    port_id_t r_last_grant;

    always_comb begin
        // NOTE: default before the case so every path assigns o_grant (no latch).
        o_grant = '0;
        case (r_last_grant)
            PORT0: begin
                if      (i_req[1]) o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
            end
            PORT1: begin
                if      (i_req[2]) o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
            end
            default: begin
                if      (i_req[0]) o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
            end
        endcase
    end

    // Reset to PORT2 so port 0 is searched first out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_grant <= PORT2;
        else if (i_upd)
            r_last_grant <= i_upd_port;
    end

endmodule

// File: rtl/router_3to1_arbiter.sv
// router_3to1_arbiter: merges three valid/ready beat streams onto one registered
// output tagged with its source port. ROUTER_PKT_LOCK_EN enables packet locking.
module router_3to1_arbiter
    import router_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS-1:0]        in_last,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [1:0]                  out_src,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    port_id_t             r_out_src;
    logic                 r_out_last;

    logic                 w_load;
    logic                 w_accept;
    logic [NUM_PORTS-1:0] w_arb_grant;
    logic [NUM_PORTS-1:0] w_grant;
    port_id_t             w_acc_port;
    logic [DATA_W-1:0]    w_acc_data;
    logic                 w_ptr_upd;
    logic                 w_out_last_d;

    rr_arbiter3 u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (in_valid),
        .i_upd      (w_ptr_upd),
        .i_upd_port (w_acc_port),
        .o_grant    (w_arb_grant)
    );

    assign w_load     = !r_out_valid || out_ready;
    assign in_ready   = w_grant & {NUM_PORTS{w_load && rst_n}};
    assign w_accept   = |in_ready;
    assign w_acc_port = onehot_to_port(w_grant);

    always_comb begin
        w_acc_data = in_data[DATA_W-1:0];
        case (w_acc_port)
            PORT1:   w_acc_data = in_data[2*DATA_W-1:DATA_W];
            PORT2:   w_acc_data = in_data[3*DATA_W-1:2*DATA_W];
            default: ;
        endcase
    end

`ifdef ROUTER_PKT_LOCK_EN
    lock_state_t r_state;
    port_id_t    r_lock_port;
    logic        w_acc_last;

    assign w_acc_last = |(in_last & w_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOCK_IDLE;
            r_lock_port <= PORT0;
        end else if (w_accept) begin
            case (r_state)
                LOCK_IDLE: begin
                    if (!w_acc_last) begin
                        r_state     <= LOCK_LOCKED;
                        r_lock_port <= w_acc_port;
                    end
                end
                LOCK_LOCKED: begin
                    if (w_acc_last) r_state <= LOCK_IDLE;
                end
                default: r_state <= LOCK_IDLE;
            endcase
        end
    end

    // A locked port that drops valid yields a bubble rather than releasing the lock.
    assign w_grant      = (r_state == LOCK_LOCKED) ? (port_to_onehot(r_lock_port) & in_valid)
                                                   : w_arb_grant;
    assign w_ptr_upd    = w_accept && w_acc_last;
    assign w_out_last_d = w_acc_last;
`else
    logic w_unused_last;

    assign w_unused_last = ^in_last;
    assign w_grant       = w_arb_grant;
    assign w_ptr_upd     = w_accept;
    assign w_out_last_d  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= PORT0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= w_acc_data;
                r_out_src  <= w_acc_port;
                r_out_last <= w_out_last_d;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_router_3to1_arbiter.sv
// tb_router_3to1_arbiter: directed stimulus from per-port beat queues, checked
// every cycle against a behavioural arbitration model plus literal expectations.
module tb_router_3to1_arbiter;

    localparam int NP = 3;
    localparam int DW = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [NP*DW-1:0] in_data   = '0;
    logic [NP-1:0]    in_valid  = '0;
    logic [NP-1:0]    in_last   = '0;
    logic [NP-1:0]    in_ready;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_src;
    logic             out_last;
    logic             out_valid;
    logic             out_ready = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0]    src_q [NP][$];
    logic [NP-1:0] hs = '0;

    // Model state: what the output port and arbitration history must be.
    logic          m_out_valid  = 1'b0;
    logic [DW-1:0] m_out_data   = '0;
    logic [1:0]    m_out_src    = 2'b00;
    logic          m_out_last   = 1'b0;
    int            m_last_grant = 2;
    bit            m_locked     = 1'b0;
    int            m_lock_port  = 0;

    logic [7:0] lk_d [4];
    logic [1:0] lk_s [4];

    router_3to1_arbiter #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                in_valid[p]          = 1'b1;
                in_data[p*DW +: DW]  = src_q[p][0][7:0];
                in_last[p]           = src_q[p][0][8];
            end else begin
                in_valid[p]          = 1'b0;
                in_data[p*DW +: DW]  = '0;
                in_last[p]           = 1'b0;
            end
        end
    endtask

    task automatic push(input int p, input logic [7:0] d, input logic l);
        src_q[p].push_back({l, d});
        drive_inputs();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [7:0] d, input logic [1:0] s);
        check({name, "_valid"}, out_valid, v);
        check({name, "_data"},  out_data,  d);
        check({name, "_src"},   out_src,   s);
    endtask

    // Round-robin search from one past the last grant; a lock pins the choice.
    function automatic int model_grant(input logic [NP-1:0] v);
        if (m_locked) return v[m_lock_port] ? m_lock_port : -1;
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (m_last_grant + k) % NP;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    // Sources pop beats the DUT took at this edge, then present the next ones.
    always @(posedge clk) begin
        for (int p = 0; p < NP; p++)
            if (hs[p]) void'(src_q[p].pop_front());
        #1;
        drive_inputs();
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out_valid  = 1'b0;
            m_out_data   = '0;
            m_out_src    = 2'b00;
            m_out_last   = 1'b0;
            m_last_grant = 2;
            m_locked     = 1'b0;
            m_lock_port  = 0;
        end else begin
            int g;
            bit load;
            load = !m_out_valid || out_ready;
            g    = load ? model_grant(in_valid) : -1;
            if (load) m_out_valid = (g >= 0);
            if (g >= 0) begin
                m_out_data = in_data[g*DW +: DW];
                m_out_src  = g[1:0];
`ifdef ROUTER_PKT_LOCK_EN
                m_out_last = in_last[g];
                if (in_last[g]) begin
                    m_last_grant = g;
                    m_locked     = 1'b0;
                end else if (!m_locked) begin
                    m_locked    = 1'b1;
                    m_lock_port = g;
                end
`else
                m_out_last   = 1'b0;
                m_last_grant = g;
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic [NP-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        if (rst_n && (!m_out_valid || out_ready)) begin
            g = model_grant(in_valid);
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        check("cyc_in_ready",  in_ready,  exp_rdy);
        check("cyc_out_valid", out_valid, m_out_valid);
        check("cyc_out_data",  out_data,  m_out_data);
        check("cyc_out_src",   out_src,   m_out_src);
        check("cyc_out_last",  out_last,  m_out_last);
        hs = in_valid & in_ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
`ifdef ROUTER_PKT_LOCK_EN
        lk_d = '{8'hC2, 8'hC3, 8'h0A, 8'h0B};
        lk_s = '{2'd2, 2'd2, 2'd0, 2'd0};
`else
        lk_d = '{8'h0A, 8'hC2, 8'h0B, 8'hC3};
        lk_s = '{2'd0, 2'd2, 2'd0, 2'd2};
`endif

        // Reset: ready held low even with a beat waiting on port 0.
        out_ready = 1'b1;
        push(0, 8'h77, 1'b1);
        repeat (2) step();
        check("rst_in_ready", in_ready, 3'b000);
        expect_out("rst", 1'b0, 8'h00, 2'b00);
        check("rst_out_last", out_last, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 3'b001);
        step();
        expect_out("first_beat", 1'b1, 8'h77, 2'd0);

        // Single port, one-cycle latency, then valid drops.
        push(1, 8'hA5, 1'b1);
        step();
        expect_out("single_a5", 1'b1, 8'hA5, 2'd1);
        step();
        check("single_drop", out_valid, 1'b0);

        // Fairness: all three continuously valid.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(0, 8'h10, 1'b1);
            push(1, 8'h20, 1'b1);
            push(2, 8'h30, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            expect_out("fair", 1'b1, 8'(16 * ((i % 3) + 1)), 2'(i % 3));
        end
        step();
        check("fair_drain", out_valid, 1'b0);

        // Backpressure: 0x3C held for 4 stalled cycles, then both waiting beats drain.
        push(0, 8'h3C, 1'b1);
        step();
        expect_out("bp_load", 1'b1, 8'h3C, 2'd0);
        out_ready = 1'b0;
        push(1, 8'h55, 1'b1);
        push(2, 8'h66, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_in_ready", in_ready, 3'b000);
            expect_out("bp_hold", 1'b1, 8'h3C, 2'd0);
        end
        out_ready = 1'b1;
        step();
        expect_out("bp_rel1", 1'b1, 8'h55, 2'd1);
        step();
        expect_out("bp_rel2", 1'b1, 8'h66, 2'd2);
        step();
        check("bp_drain", out_valid, 1'b0);

        // Packet from port 2 competing with port 0.
        do_reset();
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b0);
        push(2, 8'hC3, 1'b1);
        step();
        expect_out("pkt_c1", 1'b1, 8'hC1, 2'd2);
        push(0, 8'h0A, 1'b1);
        push(0, 8'h0B, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("pkt_seq", 1'b1, lk_d[i], lk_s[i]);
        end
        step();
        check("pkt_drain", out_valid, 1'b0);

        // Reset while stalled mid-packet; port 0 must win after release.
        do_reset();
        push(2, 8'hD1, 1'b0);
        step();
        expect_out("rs_d1", 1'b1, 8'hD1, 2'd2);
        out_ready = 1'b0;
        push(0, 8'hE0, 1'b1);
        push(2, 8'hD2, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        check("rs_in_ready", in_ready, 3'b000);
        expect_out("rs_now", 1'b0, 8'h00, 2'b00);
        check("rs_out_last", out_last, 1'b0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rs_rel_ready", in_ready, 3'b001);
        step();
        expect_out("rs_e0", 1'b1, 8'hE0, 2'd0);
        step();
        expect_out("rs_d2", 1'b1, 8'hD2, 2'd2);
        step();
        check("rs_drain", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
